// File: rtl/detector_jogada.sv
// detector_jogada: synchronise, debounce and one-hot-validate the key bank, emitting one play per actuation
module detector_jogada #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       habilita,
   input  logic [3:0] chaves,
   output logic [3:0] jogada,
   output logic       tem_jogada,
   output logic       jogada_invalida,
   output logic [3:0] db_estado
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);
   typedef enum logic [1:0] {ESPERA = 2'd0, FILTRA = 2'd1, EMITE = 2'd2, SOLTA = 2'd3} estado_t;
   estado_t estado;
   logic [3:0] s1, s, cand;
   logic [CW-1:0] cnt, cnt_inc;
   assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
   assign db_estado = {2'b00, estado};
   // two-flop synchroniser for the asynchronous keys
   always_ff @(posedge clock) begin
      if (!reset) begin
         s1 <= '0;
         s  <= '0;
      end else begin
         s1 <= chaves;
         s  <= s1;
      end
   end
   // debounce FSM: wait, filter a stable press, emit once, then wait for a stable release
   always_ff @(posedge clock) begin
      if (!reset) begin
         estado          <= ESPERA;
         cand            <= '0;
         cnt             <= '0;
         jogada          <= '0;
         tem_jogada      <= 1'b0;
         jogada_invalida <= 1'b0;
      end else begin
         tem_jogada      <= 1'b0;
         jogada_invalida <= 1'b0;
         case (estado)
            ESPERA:
               if (habilita && s != 4'd0) begin
                  estado <= FILTRA;
                  cand   <= s;
                  cnt    <= CW'(1);
               end
            FILTRA:
               if (!habilita) estado <= ESPERA;
               else if (s == cand) begin
                  cnt <= cnt_inc;
                  if (cnt_inc == CNT_MAX) estado <= EMITE;
               end else if (s == 4'd0) estado <= ESPERA;
               else begin
                  cand <= s;
                  cnt  <= CW'(1);
               end
            EMITE: begin
               estado <= SOLTA;
               cnt    <= '0;
               if ($onehot(cand)) begin
                  jogada     <= cand;
                  tem_jogada <= 1'b1;
               end else jogada_invalida <= 1'b1;
            end
            SOLTA:
               if (s != 4'd0) cnt <= '0;
               else begin
                  cnt <= cnt_inc;
                  if (cnt_inc == CNT_MAX) estado <= ESPERA;
               end
         endcase
      end
   end
endmodule

// File: tb/tb_detector_jogada.sv
// tb_detector_jogada: directed stimulus with a pulse scoreboard for detector_jogada
module tb_detector_jogada;
   logic clock = 1'b0;
   logic reset = 1'b0;
   logic habilita = 1'b1;
   logic [3:0] chaves = 4'd0;
   logic [3:0] jogada, db_estado;
   logic tem_jogada, jogada_invalida;
   int cyc = 0;
   int compared = 0;
   int mismatched = 0;
   typedef struct {int at; logic inv; logic [3:0] j;} exp_t;
   exp_t q[$];

   detector_jogada #(.DEBOUNCE_CYCLES(4)) dut (
      .clock(clock), .reset(reset), .habilita(habilita), .chaves(chaves),
      .jogada(jogada), .tem_jogada(tem_jogada), .jogada_invalida(jogada_invalida),
      .db_estado(db_estado)
   );

   always #10 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic expect_pulse(input int at, input logic inv, input logic [3:0] j);
      exp_t e;
      e.at = at;
      e.inv = inv;
      e.j = j;
      q.push_back(e);
   endtask

   always begin
      @(posedge clock);
      #1;
      if (tem_jogada || jogada_invalida) begin
         if (q.size() == 0) chk("spurious_pulse", {30'd0, tem_jogada, jogada_invalida}, 32'd0);
         else begin
            exp_t e;
            e = q.pop_front();
            chk("pulse_cycle", cyc, e.at);
            chk("pulse_kind", {30'd0, tem_jogada, jogada_invalida}, {30'd0, ~e.inv, e.inv});
            chk("pulse_jogada", {28'd0, jogada}, {28'd0, e.j});
         end
      end
   end

   initial begin
      int k;
      tick(1);
      chk("rst_db_estado", {28'd0, db_estado}, 32'd0);
      chk("rst_jogada", {28'd0, jogada}, 32'd0);
      chk("rst_pulses", {30'd0, tem_jogada, jogada_invalida}, 32'd0);
      reset = 1'b1;
      tick(1);
      // valid press 0001 held 10 cycles
      chaves = 4'b0001;
      k = cyc + 1;
      expect_pulse(k + 6, 1'b0, 4'b0001);
      tick(3);
      chk("t1_filtra", {28'd0, db_estado}, 32'd1);
      tick(3);
      chk("t1_emite", {28'd0, db_estado}, 32'd2);
      tick(1);
      chk("t1_solta", {28'd0, db_estado}, 32'd3);
      chk("t1_jogada", {28'd0, jogada}, 32'h1);
      tick(3);
      chaves = 4'd0;
      tick(8);
      chk("t1_idle", {28'd0, db_estado}, 32'd0);
      chk("t1_queue", q.size(), 32'd0);
      // 2-cycle glitch
      chaves = 4'b0100;
      tick(2);
      chaves = 4'd0;
      tick(1);
      chk("t2_filtra", {28'd0, db_estado}, 32'd1);
      tick(2);
      chk("t2_idle", {28'd0, db_estado}, 32'd0);
      chk("t2_jogada", {28'd0, jogada}, 32'h1);
      // multi-hot press
      chaves = 4'b0011;
      k = cyc + 1;
      expect_pulse(k + 6, 1'b1, 4'b0001);
      tick(10);
      chaves = 4'd0;
      tick(8);
      chk("t3_jogada", {28'd0, jogada}, 32'h1);
      chk("t3_idle", {28'd0, db_estado}, 32'd0);
      chk("t3_queue", q.size(), 32'd0);
      // long hold, short release, hold again
      chaves = 4'b1000;
      k = cyc + 1;
      expect_pulse(k + 6, 1'b0, 4'b1000);
      tick(50);
      chaves = 4'd0;
      tick(2);
      chaves = 4'b1000;
      tick(10);
      chk("t4_solta", {28'd0, db_estado}, 32'd3);
      chaves = 4'd0;
      tick(8);
      chk("t4_jogada", {28'd0, jogada}, 32'h8);
      chk("t4_idle", {28'd0, db_estado}, 32'd0);
      chk("t4_queue", q.size(), 32'd0);
      // disabled, then enabled with key held
      habilita = 1'b0;
      chaves = 4'b0010;
      tick(10);
      chk("t5_disabled", {28'd0, db_estado}, 32'd0);
      habilita = 1'b1;
      k = cyc + 1;
      expect_pulse(k + 4, 1'b0, 4'b0010);
      tick(6);
      chk("t5_jogada", {28'd0, jogada}, 32'h2);
      chaves = 4'd0;
      tick(8);
      chk("t5_queue", q.size(), 32'd0);
      // reset during filtering with key held through it
      chaves = 4'b0001;
      tick(3);
      chk("t6_filtra", {28'd0, db_estado}, 32'd1);
      reset = 1'b0;
      tick(1);
      chk("t6_rst_db", {28'd0, db_estado}, 32'd0);
      chk("t6_rst_jogada", {28'd0, jogada}, 32'd0);
      chk("t6_rst_pulses", {30'd0, tem_jogada, jogada_invalida}, 32'd0);
      reset = 1'b1;
      k = cyc + 1;
      expect_pulse(k + 6, 1'b0, 4'b0001);
      tick(10);
      chk("t6_jogada", {28'd0, jogada}, 32'h1);
      chk("t6_queue", q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
